// File: rtl/issue_interlock_ctrl_pkg.sv
// rtl/issue_interlock_ctrl_pkg.sv - shared constants and types for the ID issue interlock
package issue_interlock_ctrl_pkg;

    localparam int NREG   = 32;
    localparam int CNT_W  = 2;
    localparam int REG_AW = 5;

    typedef logic [1:0] fwd_sel_t;

    localparam fwd_sel_t FWD_RF  = 2'd0;
    localparam fwd_sel_t FWD_EX  = 2'd1;
    localparam fwd_sel_t FWD_MEM = 2'd2;
    localparam fwd_sel_t FWD_WB  = 2'd3;

    typedef struct packed {
        logic              valid;
        logic              rf_we;
        logic [REG_AW-1:0] waddr;
    } stage_wr_t;

endpackage

// File: rtl/src_fwd_sel.sv
// rtl/src_fwd_sel.sv - per-source bypass select and RAW hazard detection
module src_fwd_sel
    import issue_interlock_ctrl_pkg::*;
(
    input  logic              used,
    input  logic [REG_AW-1:0] addr,
    input  stage_wr_t         ex_wr,
    input  logic              ex_res_ready,
    input  stage_wr_t         mem_wr,
    input  logic              mem_res_ready,
    input  stage_wr_t         wb_wr,
    input  logic              cnt_nz,
    output fwd_sel_t          sel,
    output logic              hazard,
    output logic              mismatch
);

    always_comb begin
        sel      = FWD_RF;
        hazard   = 1'b0;
        mismatch = 1'b0;
        if (used && (addr != '0)) begin
            // Youngest writer wins: EX, then MEM, then WB.
            if (ex_wr.valid && ex_wr.rf_we && (ex_wr.waddr == addr)) begin
                sel    = FWD_EX;
                hazard = ~ex_res_ready;
            end else if (mem_wr.valid && mem_wr.rf_we && (mem_wr.waddr == addr)) begin
                sel    = FWD_MEM;
                hazard = ~mem_res_ready;
            end else if (wb_wr.valid && wb_wr.rf_we && (wb_wr.waddr == addr)) begin
                sel    = FWD_WB;
            end else if (cnt_nz) begin
                // Scoreboard says a writer is in flight but no stage holds it.
                hazard   = 1'b1;
                mismatch = 1'b1;
            end
        end
    end

endmodule

// File: rtl/issue_interlock_ctrl.sv
// rtl/issue_interlock_ctrl.sv - ID issue interlock with pending-writer scoreboard and bypass selects
module issue_interlock_ctrl
    import issue_interlock_ctrl_pkg::*;
#(
    parameter int NREG  = issue_interlock_ctrl_pkg::NREG,
    parameter int CNT_W = issue_interlock_ctrl_pkg::CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1_addr,
    input  logic [REG_AW-1:0] id_rs2_addr,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic              id_rf_we,
    input  logic [REG_AW-1:0] id_rf_waddr,
    input  logic              ex_allowin,
    input  logic              ex_valid,
    input  logic              ex_rf_we,
    input  logic [REG_AW-1:0] ex_rf_waddr,
    input  logic              ex_res_ready,
    input  logic              mem_valid,
    input  logic              mem_rf_we,
    input  logic [REG_AW-1:0] mem_rf_waddr,
    input  logic              mem_res_ready,
    input  logic              wb_valid,
    input  logic              wb_rf_we,
    input  logic [REG_AW-1:0] wb_rf_waddr,
    input  logic              wb_retire,
    input  logic              flush,
    output logic              id_issue,
    output logic              id_stall,
    output logic [1:0]        fwd_sel1,
    output logic [1:0]        fwd_sel2,
    output logic              sb_err
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt [NREG];
    logic [NREG-1:0]  inc;
    logic [NREG-1:0]  dec;
    logic             underflow;
    logic             haz1, haz2, mis1, mis2;
    logic             overflow;
    logic             err_set;
    stage_wr_t        ex_wr, mem_wr, wb_wr;

    assign ex_wr  = '{valid: ex_valid,  rf_we: ex_rf_we,  waddr: ex_rf_waddr};
    assign mem_wr = '{valid: mem_valid, rf_we: mem_rf_we, waddr: mem_rf_waddr};
    assign wb_wr  = '{valid: wb_valid,  rf_we: wb_rf_we,  waddr: wb_rf_waddr};

    src_fwd_sel u_src1 (
        .used          (id_rs1_used),
        .addr          (id_rs1_addr),
        .ex_wr         (ex_wr),
        .ex_res_ready  (ex_res_ready),
        .mem_wr        (mem_wr),
        .mem_res_ready (mem_res_ready),
        .wb_wr         (wb_wr),
        .cnt_nz        (cnt[id_rs1_addr] != '0),
        .sel           (fwd_sel1),
        .hazard        (haz1),
        .mismatch      (mis1)
    );

    src_fwd_sel u_src2 (
        .used          (id_rs2_used),
        .addr          (id_rs2_addr),
        .ex_wr         (ex_wr),
        .ex_res_ready  (ex_res_ready),
        .mem_wr        (mem_wr),
        .mem_res_ready (mem_res_ready),
        .wb_wr         (wb_wr),
        .cnt_nz        (cnt[id_rs2_addr] != '0),
        .sel           (fwd_sel2),
        .hazard        (haz2),
        .mismatch      (mis2)
    );

    // A saturated counter would wrap on the next issue, so hold ID until a retire.
    assign overflow = id_rf_we && (id_rf_waddr != '0) && (cnt[id_rf_waddr] == CNT_MAX);
    assign id_stall = id_valid && (haz1 || haz2 || overflow);
    assign id_issue = id_valid && !id_stall && ex_allowin && !flush;

    always_comb begin
        inc       = '0;
        dec       = '0;
        underflow = 1'b0;
        for (int r = 1; r < NREG; r++) begin
            inc[r] = id_issue && id_rf_we && (id_rf_waddr == REG_AW'(r));
            dec[r] = wb_retire && wb_valid && wb_rf_we && (wb_rf_waddr == REG_AW'(r));
            if (dec[r] && (cnt[r] == '0)) begin
                underflow = 1'b1;
            end
        end
    end

    assign err_set = underflow || (id_valid && (mis1 || mis2));

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NREG; r++) begin
                cnt[r] <= '0;
            end
            sb_err <= 1'b0;
        end else begin
            if (err_set) begin
                sb_err <= 1'b1;
            end
            for (int r = 0; r < NREG; r++) begin
                if (flush) begin
                    cnt[r] <= '0;
                end else if (inc[r] && !dec[r]) begin
                    cnt[r] <= cnt[r] + 1'b1;
                end else if (dec[r] && !inc[r] && (cnt[r] != '0)) begin
                    cnt[r] <= cnt[r] - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_issue_interlock_ctrl.sv
// tb/tb_issue_interlock_ctrl.sv - self-checking bench for issue_interlock_ctrl
module tb_issue_interlock_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid, id_rs1_used, id_rs2_used, id_rf_we;
    logic [4:0] id_rs1_addr, id_rs2_addr, id_rf_waddr;
    logic       ex_allowin;
    logic       ex_valid, ex_rf_we, ex_res_ready;
    logic [4:0] ex_rf_waddr;
    logic       mem_valid, mem_rf_we, mem_res_ready;
    logic [4:0] mem_rf_waddr;
    logic       wb_valid, wb_rf_we, wb_retire;
    logic [4:0] wb_rf_waddr;
    logic       flush;
    logic       id_issue, id_stall, sb_err;
    logic [1:0] fwd_sel1, fwd_sel2;

    int checks   = 0;
    int failures = 0;

    int   cnt_m [32];
    bit   err_m   = 1'b0;
    bit   started = 1'b0;
    bit   e_issue, e_stall, e_err_set;
    logic [1:0] e_sel1, e_sel2;

    always #5 clk = ~clk;

    issue_interlock_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .id_valid      (id_valid),
        .id_rs1_addr   (id_rs1_addr),
        .id_rs2_addr   (id_rs2_addr),
        .id_rs1_used   (id_rs1_used),
        .id_rs2_used   (id_rs2_used),
        .id_rf_we      (id_rf_we),
        .id_rf_waddr   (id_rf_waddr),
        .ex_allowin    (ex_allowin),
        .ex_valid      (ex_valid),
        .ex_rf_we      (ex_rf_we),
        .ex_rf_waddr   (ex_rf_waddr),
        .ex_res_ready  (ex_res_ready),
        .mem_valid     (mem_valid),
        .mem_rf_we     (mem_rf_we),
        .mem_rf_waddr  (mem_rf_waddr),
        .mem_res_ready (mem_res_ready),
        .wb_valid      (wb_valid),
        .wb_rf_we      (wb_rf_we),
        .wb_rf_waddr   (wb_rf_waddr),
        .wb_retire     (wb_retire),
        .flush         (flush),
        .id_issue      (id_issue),
        .id_stall      (id_stall),
        .fwd_sel1      (fwd_sel1),
        .fwd_sel2      (fwd_sel2),
        .sb_err        (sb_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Writers visible to ID listed youngest first; the first one naming the register is the source.
    task automatic src_model(input bit used, input logic [4:0] a,
                             output logic [1:0] sel, output bit haz, output bit mis);
        bit         wv  [3];
        logic [4:0] wa  [3];
        bit         rdy [3];
        bit         found = 1'b0;
        wv[0] = ex_valid  && ex_rf_we;  wa[0] = ex_rf_waddr;  rdy[0] = ex_res_ready;
        wv[1] = mem_valid && mem_rf_we; wa[1] = mem_rf_waddr; rdy[1] = mem_res_ready;
        wv[2] = wb_valid  && wb_rf_we;  wa[2] = wb_rf_waddr;  rdy[2] = 1'b1;
        sel = 2'd0; haz = 1'b0; mis = 1'b0;
        if (used && a != 5'd0) begin
            for (int k = 0; k < 3; k++) begin
                if (!found && wv[k] && wa[k] == a) begin
                    found = 1'b1;
                    sel   = 2'(k + 1);
                    haz   = !rdy[k];
                end
            end
            if (!found && cnt_m[a] != 0) begin
                haz = 1'b1;
                mis = 1'b1;
            end
        end
    endtask

    task automatic eval_model();
        bit h1, h2, m1, m2, ov, uf;
        src_model(id_rs1_used, id_rs1_addr, e_sel1, h1, m1);
        src_model(id_rs2_used, id_rs2_addr, e_sel2, h2, m2);
        ov = id_rf_we && id_rf_waddr != 5'd0 && cnt_m[id_rf_waddr] >= 3;
        e_stall = id_valid && (h1 || h2 || ov);
        e_issue = id_valid && !e_stall && ex_allowin && !flush;
        uf = wb_retire && wb_valid && wb_rf_we && wb_rf_waddr != 5'd0 && cnt_m[wb_rf_waddr] == 0;
        e_err_set = uf || (id_valid && (m1 || m2));
    endtask

    always @(posedge clk) begin
        eval_model();
        if (reset) begin
            for (int r = 0; r < 32; r++) cnt_m[r] = 0;
            err_m   = 1'b0;
            started = 1'b1;
        end else if (started) begin
            if (e_err_set) err_m = 1'b1;
            for (int r = 1; r < 32; r++) begin
                bit inc_r, dec_r;
                inc_r = e_issue && id_rf_we && id_rf_waddr == 5'(r);
                dec_r = wb_retire && wb_valid && wb_rf_we && wb_rf_waddr == 5'(r);
                if (flush) cnt_m[r] = 0;
                else if (inc_r && !dec_r) cnt_m[r] = cnt_m[r] + 1;
                else if (dec_r && !inc_r && cnt_m[r] > 0) cnt_m[r] = cnt_m[r] - 1;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            eval_model();
            check("cmp_id_issue", id_issue, e_issue);
            check("cmp_id_stall", id_stall, e_stall);
            check("cmp_fwd_sel1", fwd_sel1, e_sel1);
            check("cmp_fwd_sel2", fwd_sel2, e_sel2);
            check("cmp_sb_err",   sb_err,   err_m);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid = 0; id_rs1_used = 0; id_rs2_used = 0; id_rf_we = 0;
        id_rs1_addr = 0; id_rs2_addr = 0; id_rf_waddr = 0; ex_allowin = 1;
        ex_valid = 0; ex_rf_we = 0; ex_rf_waddr = 0; ex_res_ready = 1;
        mem_valid = 0; mem_rf_we = 0; mem_rf_waddr = 0; mem_res_ready = 1;
        wb_valid = 0; wb_rf_we = 0; wb_rf_waddr = 0; wb_retire = 0; flush = 0;
    endtask

    initial begin
        idle();
        reset = 1;
        tick();
        tick();
        reset = 0;
        #1;
        check("rst_issue", id_issue, 0);
        check("rst_stall", id_stall, 0);
        check("rst_sel1",  fwd_sel1, 0);
        check("rst_sb_err", sb_err,  0);

        // Load-use: load to r5 in EX with data not yet back.
        id_valid = 1; id_rs1_used = 1; id_rs1_addr = 5;
        ex_valid = 1; ex_rf_we = 1; ex_rf_waddr = 5; ex_res_ready = 0;
        #1;
        check("lu_stall", id_stall, 1);
        check("lu_issue", id_issue, 0);
        tick();
        ex_valid = 0; mem_valid = 1; mem_rf_we = 1; mem_rf_waddr = 5; mem_res_ready = 1;
        #1;
        check("lu_sel1_mem", fwd_sel1, 2);
        check("lu_issue_mem", id_issue, 1);
        tick();
        idle();

        // Priority: r7 in EX (ready) and WB.
        id_valid = 1; id_rs2_used = 1; id_rs2_addr = 7;
        ex_valid = 1; ex_rf_we = 1; ex_rf_waddr = 7; ex_res_ready = 1;
        wb_valid = 1; wb_rf_we = 1; wb_rf_waddr = 7;
        #1;
        check("pri_sel2_ex", fwd_sel2, 1);
        check("pri_stall", id_stall, 0);
        tick();
        ex_valid = 0;
        #1;
        check("pri_sel2_wb", fwd_sel2, 3);
        tick();
        ex_allowin = 0;
        #1;
        check("bp_issue", id_issue, 0);
        check("bp_stall", id_stall, 0);
        tick();
        idle();

        // Three writers of r9 fill the counter; the fourth must wait.
        id_valid = 1; id_rf_we = 1; id_rf_waddr = 9;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("sb_issue_n", id_issue, 1);
            tick();
        end
        check("model_cnt_r9", cnt_m[9], 3);
        check("sb_full_stall", id_stall, 1);
        check("sb_full_issue", id_issue, 0);
        flush = 1;
        #1;
        check("flush_issue", id_issue, 0);
        tick();
        flush = 0;
        #1;
        check("model_cnt_r9_flush", cnt_m[9], 0);
        check("post_flush_issue", id_issue, 1);
        check("post_flush_stall", id_stall, 0);
        tick();
        idle();

        // Simultaneous issue and retire of r3 with one writer pending.
        id_valid = 1; id_rf_we = 1; id_rf_waddr = 3;
        tick();
        wb_valid = 1; wb_rf_we = 1; wb_rf_waddr = 3; wb_retire = 1;
        #1;
        check("incdec_issue", id_issue, 1);
        tick();
        wb_valid = 0; wb_rf_we = 0; wb_retire = 0;
        check("model_cnt_r3", cnt_m[3], 1);
        check("incdec_sb_err", sb_err, 0);
        tick();
        tick();
        #1;
        check("r3_full_stall", id_stall, 1);
        tick();
        idle();
        flush = 1;
        tick();
        flush = 0;

        // r0 reads and unused sources never stall or forward.
        id_valid = 1; id_rs1_used = 1; id_rs1_addr = 0; id_rf_we = 1; id_rf_waddr = 0;
        ex_valid = 1; ex_rf_we = 1; ex_rf_waddr = 0; ex_res_ready = 0;
        #1;
        check("r0_sel1", fwd_sel1, 0);
        check("r0_stall", id_stall, 0);
        check("r0_issue", id_issue, 1);
        tick();
        check("model_cnt_r0", cnt_m[0], 0);
        id_rs1_used = 0; id_rs2_used = 0; id_rs2_addr = 6; id_rf_we = 0; ex_rf_waddr = 6;
        #1;
        check("unused_sel2", fwd_sel2, 0);
        check("unused_stall", id_stall, 0);
        tick();
        idle();

        // Retire with nothing pending, then reset clears the sticky flag.
        wb_valid = 1; wb_rf_we = 1; wb_rf_waddr = 4; wb_retire = 1;
        tick();
        idle();
        #1;
        check("err_set", sb_err, 1);
        tick();
        check("err_sticky", sb_err, 1);
        id_valid = 1; id_rf_we = 1; id_rf_waddr = 9;
        tick();
        idle();
        reset = 1;
        tick();
        reset = 0;
        #1;
        check("rst2_sb_err", sb_err, 0);
        id_valid = 1; id_rs1_used = 1; id_rs1_addr = 9;
        #1;
        check("rst2_cnt_clear_stall", id_stall, 0);
        tick();
        idle();
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
